noc_push_arbiter: RTL and testbench

Packet-granular round-robin arbiter that shares the push side of one NoC word queue between N requesting cores. Each requester presents a TIE-style push interface (PushReq / data / Full). The arbiter grants one requester at a time and holds the grant for exactly PKT_LEN accepted words, so packets are never interleaved in the queue. It sits between the core TIE_NoC_OUT ports and the `queue` push port (PushReq / data / Full).

---
 rtl/noc_push_arbiter.sv | 135 +++++++++++++
 tb/tb_noc_push_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_push_arbiter.sv
// noc_push_arbiter
// Packet-granular round-robin arbiter sharing the push side of one NoC word
// queue between N requesters. A grant is held for exactly PKT_LEN accepted
// words so packets never interleave in the queue.
//
// Ports
//   CLK          clock, all state updates on posedge
//   RESET_N      asynchronous active-low reset
//   REQ_PushReq  per-requester push request (bit i = requester i)
//   REQ_Data     per-requester word, requester i on [i*DW +: DW]
//   REQ_Full     per-requester back-pressure (only the owner can see 0)
//   Q_PushReq    push request to the queue
//   Q_Data       word to the queue
//   Q_Full       queue full
//   GRANT        one-hot owner while LOCKED, zero while IDLE
//   PKT_DONE     registered pulse in the IDLE cycle after a packet's last word
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | no owner; arbitrate among current requests starting at ptr
// ST_LOCKED | owner holds the queue until PKT_LEN words have been accepted
module noc_push_arbiter #(
  parameter int N       = 4,
  parameter int PKT_LEN = 4,
  parameter int DW      = 32
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic [N-1:0]    REQ_PushReq,
  input  logic [N*DW-1:0] REQ_Data,
  output logic [N-1:0]    REQ_Full,
  output logic            Q_PushReq,
  output logic [DW-1:0]   Q_Data,
  input  logic            Q_Full,
  output logic [N-1:0]    GRANT,
  output logic            PKT_DONE
);

  localparam int OW = (N > 1) ? $clog2(N) : 1;
  localparam int IW = OW + 1;
  localparam int CW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PKT_LEN - 1);
  localparam logic [OW-1:0] OWN_LAST = OW'(N - 1);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  state_e        st_q, st_d;
  logic [OW-1:0] owner_q, owner_d;
  logic [OW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;

  logic [OW-1:0] pick;
  logic          pick_vld;
  logic [IW-1:0] idx_w;
  logic          xfer;

  // Rotating priority search: first requester at or after ptr, wrapping mod N.
  always_comb begin : rr_search
    pick     = '0;
    pick_vld = 1'b0;
    idx_w    = '0;
    for (int k = 0; k < N; k++) begin
      idx_w = {1'b0, ptr_q} + IW'(k);
      if (idx_w >= IW'(N)) idx_w = idx_w - IW'(N);
      if (!pick_vld && REQ_PushReq[idx_w[OW-1:0]]) begin
        pick     = idx_w[OW-1:0];
        pick_vld = 1'b1;
      end
    end
  end

  assign xfer = (st_q == ST_LOCKED) && REQ_PushReq[owner_q] && !Q_Full;

  always_comb begin : fsm_comb
    st_d      = st_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    Q_PushReq = 1'b0;
    Q_Data    = '0;
    REQ_Full  = '1;
    GRANT     = '0;

    case (st_q)
      ST_IDLE: begin
        if (pick_vld) begin
          owner_d = pick;
          cnt_d   = '0;
          st_d    = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        Q_PushReq         = REQ_PushReq[owner_q];
        Q_Data            = REQ_Data[int'(owner_q)*DW +: DW];
        REQ_Full[owner_q] = Q_Full;
        GRANT[owner_q]    = 1'b1;
        if (xfer) begin
          if (cnt_q == CNT_LAST) begin
            st_d   = ST_IDLE;
            cnt_d  = '0;
            ptr_d  = (owner_q == OWN_LAST) ? '0 : owner_q + 1'b1;
            done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      st_q    <= ST_IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign PKT_DONE = done_q;

endmodule

// File: tb/tb_noc_push_arbiter.sv
module tb_noc_push_arbiter;

  localparam int N       = 4;
  localparam int PKT_LEN = 4;
  localparam int DW      = 32;

  logic            CLK = 1'b0;
  logic            RESET_N;
  logic [N-1:0]    REQ_PushReq;
  logic [N*DW-1:0] REQ_Data;
  logic [N-1:0]    REQ_Full;
  logic            Q_PushReq;
  logic [DW-1:0]   Q_Data;
  logic            Q_Full;
  logic [N-1:0]    GRANT;
  logic            PKT_DONE;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: packet owner plus words still owed in the current packet.
  bit m_busy;
  int m_owner;
  int m_ptr;
  int m_left;
  bit m_done;

  logic [N-1:0]  e_grant, e_full;
  logic          e_qpush, e_done;
  logic [DW-1:0] e_qdata;

  noc_push_arbiter #(.N(N), .PKT_LEN(PKT_LEN), .DW(DW)) dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .REQ_PushReq(REQ_PushReq),
    .REQ_Data   (REQ_Data),
    .REQ_Full   (REQ_Full),
    .Q_PushReq  (Q_PushReq),
    .Q_Data     (Q_Data),
    .Q_Full     (Q_Full),
    .GRANT      (GRANT),
    .PKT_DONE   (PKT_DONE)
  );

  always #5 CLK = ~CLK;

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_ptr = 0; m_left = 0; m_done = 0;
  endtask

  task automatic model_expect();
    e_grant = '0; e_full = '1; e_qpush = 1'b0; e_qdata = '0; e_done = m_done;
    if (m_busy) begin
      e_grant[m_owner] = 1'b1;
      e_full[m_owner]  = Q_Full;
      e_qpush          = REQ_PushReq[m_owner];
      e_qdata          = REQ_Data[m_owner*DW +: DW];
    end
  endtask

  task automatic tick();
    bit d;
    d = 0;
    @(posedge CLK);
    if (!m_busy) begin
      for (int k = 0; k < N; k++) begin
        int c = (m_ptr + k) % N;
        if (REQ_PushReq[c]) begin
          m_owner = c; m_left = PKT_LEN; m_busy = 1;
          break;
        end
      end
    end else if (REQ_PushReq[m_owner] && !Q_Full) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_busy = 0;
        m_ptr  = (m_owner + 1) % N;
        d      = 1;
      end
    end
    m_done = d;
    #1;
  endtask

  task automatic apply_reset();
    RESET_N = 1'b0;
    model_reset();
    #1;
    RESET_N = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    RESET_N = 1'b0; REQ_PushReq = 4'b1111; REQ_Data = '0; Q_Full = 1'b0;
    model_reset();
    #1;
    n_vec++; if (GRANT !== 4'b0000) begin n_err++; $display("FAIL reset_grant: got %b want 0000", GRANT); end
    n_vec++; if (REQ_Full !== 4'b1111) begin n_err++; $display("FAIL reset_full: got %b want 1111", REQ_Full); end
    n_vec++; if (Q_PushReq !== 1'b0) begin n_err++; $display("FAIL reset_qpush: got %b want 0", Q_PushReq); end
    n_vec++; if (PKT_DONE !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", PKT_DONE); end
    @(posedge CLK); @(posedge CLK); #1;
    n_vec++; if (GRANT !== 4'b0000) begin n_err++; $display("FAIL reset_hold_grant: got %b want 0000", GRANT); end
    RESET_N = 1'b1;
    REQ_PushReq = 4'b0000;
    #1;
    tick();
    n_vec++; if (GRANT !== 4'b0000) begin n_err++; $display("FAIL idle_noreq_grant: got %b want 0000", GRANT); end
  endtask

  task automatic test_single();
    logic [N-1:0] t_grant [7] = '{4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0001};
    bit           t_done  [7] = '{0, 0, 0, 0, 0, 1, 0};
    bit           t_xfer  [7] = '{0, 1, 1, 1, 1, 0, 1};
    int sent = 0;
    logic [DW-1:0] want;
    apply_reset();
    REQ_PushReq = 4'b0001; Q_Full = 1'b0; REQ_Data = '0;
    for (int cyc = 0; cyc < 7; cyc++) begin
      want = DW'(32'hA0 + (sent % PKT_LEN));
      REQ_Data[0 +: DW] = want;
      #1;
      n_vec++; if (GRANT !== t_grant[cyc]) begin n_err++; $display("FAIL single_grant c%0d: got %b want %b", cyc, GRANT, t_grant[cyc]); end
      n_vec++; if (PKT_DONE !== t_done[cyc]) begin n_err++; $display("FAIL single_done c%0d: got %b want %b", cyc, PKT_DONE, t_done[cyc]); end
      n_vec++; if (Q_PushReq !== t_xfer[cyc]) begin n_err++; $display("FAIL single_qpush c%0d: got %b want %b", cyc, Q_PushReq, t_xfer[cyc]); end
      if (t_xfer[cyc]) begin
        n_vec++; if (Q_Data !== want) begin n_err++; $display("FAIL single_qdata c%0d: got %h want %h", cyc, Q_Data, want); end
        sent++;
      end
      tick();
    end
  endtask

  task automatic test_round_robin();
    int exp_own [5] = '{0, 1, 2, 3, 0};
    int p = 0;
    int w = 0;
    logic [N-1:0] g;
    apply_reset();
    REQ_PushReq = 4'b1111; Q_Full = 1'b0;
    for (int cyc = 0; cyc < 60 && p < 5; cyc++) begin
      for (int i = 0; i < N; i++) REQ_Data[i*DW +: DW] = {16'h0, 8'(i), 8'(cyc)};
      #1;
      g = '0; g[exp_own[p]] = 1'b1;
      if (GRANT !== 4'b0000) begin
        n_vec++; if (GRANT !== g) begin n_err++; $display("FAIL rr_grant pkt%0d: got %b want %b", p, GRANT, g); end
        if (Q_PushReq && !Q_Full) begin
          n_vec++; if (Q_Data[15:8] !== 8'(exp_own[p])) begin n_err++; $display("FAIL rr_word_src pkt%0d: got %0d want %0d", p, Q_Data[15:8], exp_own[p]); end
          w++;
        end
      end
      if (PKT_DONE) begin
        n_vec++; if (w !== PKT_LEN) begin n_err++; $display("FAIL rr_pkt_len pkt%0d: got %0d want %0d", p, w, PKT_LEN); end
        p++; w = 0;
      end
      tick();
    end
    n_vec++; if (p !== 5) begin n_err++; $display("FAIL rr_timeout: got %0d packets want 5", p); end
  endtask

  task automatic test_backpressure();
    int xf = 0;
    bit seen = 0;
    apply_reset();
    REQ_PushReq = 4'b0001; REQ_Data = '0;
    for (int cyc = 0; cyc < 14 && !seen; cyc++) begin
      Q_Full = (cyc >= 2 && cyc <= 4);
      REQ_Data[0 +: DW] = DW'(cyc);
      #1;
      if (cyc >= 2 && cyc <= 4) begin
        n_vec++; if (Q_PushReq !== 1'b1) begin n_err++; $display("FAIL bp_qpush c%0d: got %b want 1", cyc, Q_PushReq); end
        n_vec++; if (REQ_Full !== 4'b1111) begin n_err++; $display("FAIL bp_full c%0d: got %b want 1111", cyc, REQ_Full); end
        n_vec++; if (GRANT !== 4'b0001) begin n_err++; $display("FAIL bp_grant c%0d: got %b want 0001", cyc, GRANT); end
      end
      if (Q_PushReq && !Q_Full) xf++;
      if (PKT_DONE) begin
        seen = 1;
        n_vec++; if (cyc !== 8) begin n_err++; $display("FAIL bp_done_cycle: got %0d want 8", cyc); end
        n_vec++; if (xf !== PKT_LEN) begin n_err++; $display("FAIL bp_words: got %0d want %0d", xf, PKT_LEN); end
      end
      tick();
    end
    n_vec++; if (!seen) begin n_err++; $display("FAIL bp_timeout: got no PKT_DONE want one"); end
    Q_Full = 1'b0;
  endtask

  task automatic test_wrap_skip();
    int own [2];
    int np = 0;
    bit prev_idle = 1;
    bit seen = 0;
    apply_reset();
    REQ_PushReq = 4'b0100; Q_Full = 1'b0;
    for (int cyc = 0; cyc < 20 && !seen; cyc++) begin
      #1;
      if (PKT_DONE) seen = 1;
      else tick();
    end
    n_vec++; if (!seen) begin n_err++; $display("FAIL wrap_setup_timeout: got no PKT_DONE want one"); end
    REQ_PushReq = 4'b0101;
    for (int cyc = 0; cyc < 40 && np < 2; cyc++) begin
      tick();
      n_vec++; if (GRANT[1] !== 1'b0) begin n_err++; $display("FAIL wrap_skip1: got GRANT %b want bit1 clear", GRANT); end
      if (GRANT !== 4'b0000 && prev_idle) begin
        own[np] = (GRANT == 4'b0001) ? 0 : (GRANT == 4'b0100) ? 2 : -1;
        np++;
      end
      prev_idle = (GRANT === 4'b0000);
    end
    n_vec++; if (np !== 2) begin n_err++; $display("FAIL wrap_timeout: got %0d grants want 2", np); end
    else begin
      n_vec++; if (own[0] !== 0) begin n_err++; $display("FAIL wrap_first_owner: got %0d want 0", own[0]); end
      n_vec++; if (own[1] !== 2) begin n_err++; $display("FAIL wrap_second_owner: got %0d want 2", own[1]); end
    end
  endtask

  task automatic test_owner_stall();
    int xf = 0;
    bit seen = 0;
    apply_reset();
    REQ_PushReq = 4'b0001; Q_Full = 1'b0; REQ_Data = '0;
    tick(); tick(); tick();
    REQ_PushReq = 4'b0100;
    for (int cyc = 0; cyc < 5; cyc++) begin
      #1;
      n_vec++; if (GRANT !== 4'b0001) begin n_err++; $display("FAIL stall_grant c%0d: got %b want 0001", cyc, GRANT); end
      n_vec++; if (REQ_Full[2] !== 1'b1) begin n_err++; $display("FAIL stall_full2 c%0d: got %b want 1", cyc, REQ_Full[2]); end
      n_vec++; if (Q_PushReq !== 1'b0) begin n_err++; $display("FAIL stall_qpush c%0d: got %b want 0", cyc, Q_PushReq); end
      tick();
    end
    REQ_PushReq = 4'b0101;
    for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
      #1;
      if (PKT_DONE) seen = 1;
      else begin
        if (Q_PushReq && !Q_Full) xf++;
        tick();
      end
    end
    n_vec++; if (!seen || xf !== 2) begin n_err++; $display("FAIL stall_resume: got %0d words done=%0d want 2 done=1", xf, seen); end
    tick();
    n_vec++; if (GRANT !== 4'b0100) begin n_err++; $display("FAIL stall_next_owner: got %b want 0100", GRANT); end
  endtask

  task automatic test_async_reset();
    bit seen = 0;
    apply_reset();
    REQ_PushReq = 4'b0010; Q_Full = 1'b0;
    for (int cyc = 0; cyc < 20 && !seen; cyc++) begin
      #1;
      if (PKT_DONE) seen = 1;
      else tick();
    end
    REQ_PushReq = 4'b1111;
    tick(); tick(); tick();
    n_vec++; if (GRANT !== 4'b0100) begin n_err++; $display("FAIL areset_pre_grant: got %b want 0100", GRANT); end
    RESET_N = 1'b0;
    model_reset();
    #1;
    n_vec++; if (GRANT !== 4'b0000) begin n_err++; $display("FAIL areset_grant: got %b want 0000", GRANT); end
    n_vec++; if (REQ_Full !== 4'b1111) begin n_err++; $display("FAIL areset_full: got %b want 1111", REQ_Full); end
    n_vec++; if (Q_PushReq !== 1'b0) begin n_err++; $display("FAIL areset_qpush: got %b want 0", Q_PushReq); end
    RESET_N = 1'b1;
    #1;
    tick();
    n_vec++; if (GRANT !== 4'b0001) begin n_err++; $display("FAIL areset_restart: got %b want 0001", GRANT); end
  endtask

  task automatic test_random();
    apply_reset();
    REQ_PushReq = '0; Q_Full = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if ($urandom_range(0, 3) == 0) REQ_PushReq = N'($urandom_range(0, 15));
      Q_Full = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < N; i++) REQ_Data[i*DW +: DW] = $urandom;
      #1;
      model_expect();
      n_vec++; if (GRANT !== e_grant) begin n_err++; $display("FAIL rnd_grant c%0d: got %b want %b", cyc, GRANT, e_grant); end
      n_vec++; if (REQ_Full !== e_full) begin n_err++; $display("FAIL rnd_full c%0d: got %b want %b", cyc, REQ_Full, e_full); end
      n_vec++; if (Q_PushReq !== e_qpush) begin n_err++; $display("FAIL rnd_qpush c%0d: got %b want %b", cyc, Q_PushReq, e_qpush); end
      n_vec++; if (Q_Data !== e_qdata) begin n_err++; $display("FAIL rnd_qdata c%0d: got %h want %h", cyc, Q_Data, e_qdata); end
      n_vec++; if (PKT_DONE !== e_done) begin n_err++; $display("FAIL rnd_done c%0d: got %b want %b", cyc, PKT_DONE, e_done); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_wrap_skip();
    test_owner_stall();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
